// File: rtl/sqrt_share_ctrl.sv
// Round-robin scheduler in front of one shared iterative 64-bit square-root core.
// Grants one requester at a time, loads its operand, releases the core from reset,
// captures the root on the first ready, and returns it with a one-cycle ack.
// A hung core is caught by a RUN-cycle timeout that completes with err set.
module sqrt_share_ctrl #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TIMEOUT = 40
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*64-1:0]   x_in,
  output logic [NREQ-1:0]      ack,
  output logic [31:0]          y_out,
  output logic [IDW-1:0]       y_id,
  output logic                 err,
  output logic                 busy,
  output logic                 core_reset,
  output logic [63:0]          core_x,
  input  logic                 core_rdy,
  input  logic [31:0]          core_y
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] g;
  logic [CW-1:0]  cnt;

  logic [IDW-1:0] grant;
  logic [IDW-1:0] grant_hi;
  logic [IDW-1:0] grant_lo;
  logic           found;
  logic           found_hi;
  logic           found_lo;

  // Round-robin pick: lowest requester above ptr, else lowest at or below ptr.
  always_comb begin
    grant_hi = '0;
    grant_lo = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int j = 0; j < int'(NREQ); j++) begin
      if (req[j] && (j > int'(ptr)) && !found_hi) begin
        grant_hi = IDW'(j);
        found_hi = 1'b1;
      end
      if (req[j] && (j <= int'(ptr)) && !found_lo) begin
        grant_lo = IDW'(j);
        found_lo = 1'b1;
      end
    end
    found = found_hi | found_lo;
    grant = found_hi ? grant_hi : grant_lo;
  end

  // Busy covers the whole time a requester owns the core.
  always_comb begin
    busy = (state != StIdle);
  end

  // Control FSM with registered outputs; ack and err are single-cycle pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= StIdle;
      core_reset <= 1'b1;
      core_x     <= '0;
      ack        <= '0;
      y_out      <= '0;
      y_id       <= '0;
      err        <= 1'b0;
      ptr        <= IDW'(NREQ - 1);
      g          <= '0;
      cnt        <= '0;
    end else begin
      ack <= '0;
      err <= 1'b0;
      case (state)
        StIdle: begin
          core_reset <= 1'b1;
          if (found) begin
            core_x     <= x_in[64*grant +: 64];
            g          <= grant;
            ptr        <= grant;
            cnt        <= '0;
            core_reset <= 1'b0;
            state      <= StRun;
          end
        end
        StRun: begin
          cnt <= cnt + 1'b1;
          // cnt guard ignores a ready flag left over from before the core was released.
          if (core_rdy && (cnt != '0)) begin
            y_out      <= core_y;
            err        <= 1'b0;
            ack[g]     <= 1'b1;
            y_id       <= g;
            core_reset <= 1'b1;
            state      <= StDone;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            y_out      <= '0;
            err        <= 1'b1;
            ack[g]     <= 1'b1;
            y_id       <= g;
            core_reset <= 1'b1;
            state      <= StDone;
          end else if (!req[g]) begin
            // Requester withdrew: drop the operation without an ack.
            core_reset <= 1'b1;
            state      <= StIdle;
          end
        end
        StDone: begin
          core_reset <= 1'b1;
          state      <= StIdle;
        end
        default: begin
          core_reset <= 1'b1;
          state      <= StIdle;
        end
      endcase
    end
  end

endmodule
